array_op_sequencer: RTL and testbench

Sequences one array-decoder operation at a time over the column-selection datapath. It accepts a command (read memory, program/form pulse, inference sweep or read-out) on a valid/ready handshake. It then drives the shared `CBL`, `CBLEN`, `CSL`, `read_out` and `adr_full_col` lines with fixed setup, active and recovery phases, and signals completion with a one-cycle `done` pulse. It sits between the host/command logic and `array_decoder_top`, and is the only driver of the decoder's control inputs.

---
 rtl/fraise_seq_pkg.sv | 50 +++++
 rtl/array_op_sequencer_if.sv | 30 +++
 rtl/array_op_sequencer.sv | 134 +++++++++++++
 tb/tb_array_op_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fraise_seq_pkg.sv
// Shared types and constants for the array operation sequencer.
// Provides the opcode enum, the sequencer state enum, the strobe bundle
// type and the per-opcode strobe masks applied during SETUP and ACT.
package fraise_seq_pkg;

    typedef enum logic [1:0] {
        READ_MEM = 2'b00,
        PROGRAM  = 2'b01,
        INFER    = 2'b10,
        READ_OUT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACT,
        RECOVER
    } seq_state_e;

    // Decoder control lines that are switched together as one bundle
    typedef struct packed {
        logic cbl;
        logic cblen;
        logic csl;
        logic read_out;
    } strobe_t;

    localparam strobe_t STB_NONE       = '{cbl: 1'b0, cblen: 1'b0, csl: 1'b0, read_out: 1'b0};
    localparam strobe_t STB_SETUP_PROG = '{cbl: 1'b0, cblen: 1'b1, csl: 1'b0, read_out: 1'b0};
    localparam strobe_t STB_ACT_READ   = '{cbl: 1'b0, cblen: 1'b1, csl: 1'b1, read_out: 1'b0};
    localparam strobe_t STB_ACT_PROG   = '{cbl: 1'b1, cblen: 1'b1, csl: 1'b0, read_out: 1'b0};
    localparam strobe_t STB_ACT_INFER  = '{cbl: 1'b0, cblen: 1'b1, csl: 1'b1, read_out: 1'b0};
    localparam strobe_t STB_ACT_ROUT   = '{cbl: 1'b0, cblen: 1'b0, csl: 1'b0, read_out: 1'b1};

    // Only PROGRAM pre-charges CBLEN during address setup
    function automatic strobe_t setup_strobes(op_e op);
        return (op == PROGRAM) ? STB_SETUP_PROG : STB_NONE;
    endfunction

    function automatic strobe_t act_strobes(op_e op);
        case (op)
            READ_MEM: return STB_ACT_READ;
            PROGRAM:  return STB_ACT_PROG;
            INFER:    return STB_ACT_INFER;
            READ_OUT: return STB_ACT_ROUT;
            default:  return STB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/array_op_sequencer_if.sv
// Command-side interface of the array operation sequencer.
// Ports:
//   cmd_valid/cmd_ready  valid/ready command handshake
//   cmd_op               requested operation
//   cmd_adr              target column address (N bits)
//   abort                terminate the operation in progress
//   done/aborted         one-cycle completion pulse and its abort qualifier
interface array_op_sequencer_if
    import fraise_seq_pkg::*;
#(
    parameter int N = 5
);
    logic           cmd_valid;
    logic           cmd_ready;
    op_e            cmd_op;
    logic [N-1:0]   cmd_adr;
    logic           abort;
    logic           done;
    logic           aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_adr, abort,
        input  cmd_ready, done, aborted
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_adr, abort,
        output cmd_ready, done, aborted
    );
endinterface

// File: rtl/array_op_sequencer.sv
// Sequences one array-decoder operation at a time: accepts a command,
// then walks SETUP / ACT / RECOVER phases driving the decoder strobes and
// column address, and pulses done when finished. INFER repeats the
// phase triple once per word of the selected array.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   cmd            command interface (slave side)
//   adr_full_col   column address to the decoder
//   CBL/CBLEN/CSL  decoder strobes
//   read_out       decoder read-out select
module array_op_sequencer
    import fraise_seq_pkg::*;
#(
    parameter int Nword    = 3,
    parameter int Narray   = 2,
    parameter int N        = Nword + Narray,
    parameter int M        = 2 ** Nword,
    parameter int PROG_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    array_op_sequencer_if.slave   cmd,
    output logic [N-1:0]          adr_full_col,
    output logic                  CBL,
    output logic                  CBLEN,
    output logic                  CSL,
    output logic                  read_out
);

    localparam logic [Nword-1:0] LAST_WORD = Nword'(M - 1);
    localparam logic [7:0]       PROG_LOAD = 8'(PROG_CYC - 1);

    seq_state_e        state;
    op_e               op_q;
    logic [N-1:0]      adr_q;
    logic [Nword-1:0]  word_cnt;
    logic [Nword-1:0]  next_cnt;
    logic [7:0]        phase_cnt;
    logic              abort_q;
    strobe_t           stb;
    logic              done_q;
    logic              aborted_q;

    assign next_cnt      = word_cnt + 1'b1;
    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.done      = done_q;
    assign cmd.aborted   = aborted_q;
    assign CBL           = stb.cbl;
    assign CBLEN         = stb.cblen;
    assign CSL           = stb.csl;
    assign read_out      = stb.read_out;

    // Address presented for a word: READ_OUT never addresses a column and
    // INFER substitutes the word counter for the low address bits.
    function automatic logic [N-1:0] word_addr(op_e op, logic [N-1:0] base,
                                               logic [Nword-1:0] cnt);
        case (op)
            READ_OUT: return '0;
            INFER:    return {base[N-1:Nword], cnt};
            default:  return base;
        endcase
    endfunction

    // Phase sequencer. All decoder-facing outputs are loaded on the same
    // edge as the state they belong to, so the address only moves on entry
    // to SETUP or IDLE while the strobes are all low. An abort seen in
    // SETUP/ACT is remembered in abort_q so RECOVER can finish the cycle
    // and still report it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= READ_MEM;
            adr_q        <= '0;
            word_cnt     <= '0;
            phase_cnt    <= '0;
            abort_q      <= 1'b0;
            stb          <= STB_NONE;
            adr_full_col <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q         <= cmd.cmd_op;
                        adr_q        <= cmd.cmd_adr;
                        word_cnt     <= '0;
                        abort_q      <= 1'b0;
                        adr_full_col <= word_addr(cmd.cmd_op, cmd.cmd_adr, '0);
                        stb          <= setup_strobes(cmd.cmd_op);
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    phase_cnt <= (op_q == PROGRAM) ? PROG_LOAD : 8'd0;
                    if (cmd.abort) begin
                        abort_q <= 1'b1;
                        stb     <= STB_NONE;
                        state   <= RECOVER;
                    end else begin
                        stb     <= act_strobes(op_q);
                        state   <= ACT;
                    end
                end
                ACT: begin
                    if (cmd.abort || phase_cnt == 8'd0) begin
                        abort_q <= cmd.abort;
                        stb     <= STB_NONE;
                        state   <= RECOVER;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                RECOVER: begin
                    if (!abort_q && !cmd.abort && op_q == INFER && word_cnt != LAST_WORD) begin
                        word_cnt     <= next_cnt;
                        adr_full_col <= word_addr(op_q, adr_q, next_cnt);
                        stb          <= setup_strobes(op_q);
                        state        <= SETUP;
                    end else begin
                        adr_full_col <= '0;
                        done_q       <= 1'b1;
                        aborted_q    <= abort_q | cmd.abort;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_op_sequencer.sv
// Self-checking bench for array_op_sequencer. Each command pushes its
// expected per-cycle output trace into a scoreboard queue; the trace is
// popped and compared one entry per clock while the DUT runs.
module tb_array_op_sequencer;
    import fraise_seq_pkg::*;

    localparam int PROG_CYC = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  adr_full_col;
    logic        CBL, CBLEN, CSL, read_out;
    logic [11:0] obs;
    logic [11:0] expv;
    logic [11:0] sb_q[$];
    int          total;
    int          bad;

    array_op_sequencer_if #(.N(5)) bus ();

    array_op_sequencer #(
        .Nword(3), .Narray(2), .PROG_CYC(PROG_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(bus.slave),
        .adr_full_col(adr_full_col),
        .CBL(CBL),
        .CBLEN(CBLEN),
        .CSL(CSL),
        .read_out(read_out)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {adr_full_col, CBL, CBLEN, CSL, read_out, bus.done, bus.aborted, bus.cmd_ready};

    function automatic logic [11:0] vec(logic [4:0] a, logic cbl, logic cblen, logic csl,
                                        logic ro, logic dn, logic ab, logic rdy);
        return {a, cbl, cblen, csl, ro, dn, ab, rdy};
    endfunction

    // Reference trace for one command, cycle 1 onward after the accept edge.
    // abort_word >= 0 ends the sweep after that word's RECOVER with aborted set.
    task automatic push_op(input op_e op, input logic [4:0] adr, input int abort_word);
        int         words;
        int         len;
        logic [4:0] a;
        logic       ab;
        words = (op == INFER) ? 8 : 1;
        len   = (op == PROGRAM) ? PROG_CYC : 1;
        ab    = 1'b0;
        for (int w = 0; w < words; w++) begin
            if (op == READ_OUT)   a = 5'd0;
            else if (op == INFER) a = {adr[4:3], 3'(w)};
            else                  a = adr;
            sb_q.push_back(vec(a, 1'b0, op == PROGRAM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int c = 0; c < len; c++) begin
                case (op)
                    PROGRAM:  sb_q.push_back(vec(a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                    READ_OUT: sb_q.push_back(vec(a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                    default:  sb_q.push_back(vec(a, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                endcase
            end
            sb_q.push_back(vec(a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            if (w == abort_word) begin
                ab = 1'b1;
                break;
            end
        end
        sb_q.push_back(vec(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ab, 1'b1));
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = READ_MEM;
        bus.cmd_adr   = '0;
        bus.abort     = 1'b0;
        #12;
        total++;
        if (obs !== 12'h001) begin
            bad++;
            $display("[TB] FAIL reset_hold: got %h want %h", obs, 12'h001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (obs !== 12'h001) begin
            bad++;
            $display("[TB] FAIL reset_release: got %h want %h", obs, 12'h001);
        end
        @(posedge clk); #1;
    endtask

    // READ_MEM issued with abort high on the accept edge: abort must be ignored
    task automatic test_read_mem;
        int c;
        push_op(READ_MEM, 5'b10_011, -1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = READ_MEM;
        bus.cmd_adr   = 5'b10_011;
        bus.abort     = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        c = 1;
        while (sb_q.size() != 0) begin
            @(negedge clk);
            expv = sb_q.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL read_mem cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic test_program;
        int c;
        push_op(PROGRAM, 5'b01_111, -1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = PROGRAM;
        bus.cmd_adr   = 5'b01_111;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        c = 1;
        while (sb_q.size() != 0) begin
            bus.cmd_op  = READ_OUT;
            bus.cmd_adr = 5'b11_000;
            @(negedge clk);
            expv = sb_q.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL program cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic test_infer;
        int c;
        push_op(INFER, 5'b11_101, -1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = INFER;
        bus.cmd_adr   = 5'b11_101;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        c = 1;
        while (sb_q.size() != 0) begin
            @(negedge clk);
            expv = sb_q.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL infer cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
            c++;
        end
    endtask

    // Abort during ACT of word 2 (cycle 8) and during RECOVER of word 0 (cycle 3)
    task automatic test_abort;
        int c;
        int ac;
        for (int k = 0; k < 2; k++) begin
            ac = (k == 0) ? 8 : 3;
            push_op(INFER, 5'b01_000, (k == 0) ? 2 : 0);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = INFER;
            bus.cmd_adr   = 5'b01_000;
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            c = 1;
            while (sb_q.size() != 0) begin
                bus.abort = (c == ac);
                @(negedge clk);
                expv = sb_q.pop_front();
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("[TB] FAIL abort%0d cyc%0d: got %h want %h", k, c, obs, expv);
                end
                @(posedge clk); #1;
                c++;
            end
            bus.abort = 1'b0;
        end
    endtask

    // READ_OUT then a READ_MEM held on cmd_valid, accepted on the done cycle
    task automatic test_back_to_back;
        int c;
        push_op(READ_OUT, 5'b10_101, -1);
        push_op(READ_MEM, 5'b00_110, -1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = READ_OUT;
        bus.cmd_adr   = 5'b10_101;
        @(posedge clk); #1;
        bus.cmd_op    = READ_MEM;
        bus.cmd_adr   = 5'b00_110;
        c = 1;
        while (sb_q.size() != 0) begin
            if (c == 5) bus.cmd_valid = 1'b0;
            @(negedge clk);
            expv = sb_q.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL back_to_back cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic test_reset_mid_program;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = PROGRAM;
        bus.cmd_adr   = 5'b00_101;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        expv = vec(5'b00_101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL mid_prog_act: got %h want %h", obs, expv);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 12'h001) begin
            bad++;
            $display("[TB] FAIL async_reset: got %h want %h", obs, 12'h001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs !== 12'h001) begin
                bad++;
                $display("[TB] FAIL post_reset%0d: got %h want %h", i, obs, 12'h001);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_read_mem();
        test_program();
        test_infer();
        test_abort();
        test_back_to_back();
        test_reset_mid_program();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
